mem_req_arbiter: RTL and testbench

Single-owner request arbiter in front of the byte-serial memory controller. Accepts instruction fetches from the icache, loads and stores from the LSB, grants one at a time, issues one command to the controller, and routes the completion back with an acknowledge pulse. It owns load sign/zero extension and squashes fetch/load results across a pipeline flush.

---
 rtl/mem_req_arbiter_pkg.sv | 33 +++
 rtl/mem_load_ext.sv | 25 ++
 rtl/mem_req_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_req_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_arbiter_pkg.sv
// mem_req_arbiter_pkg: shared constants for the memory request arbiter.
//   state_e    - arbiter FSM states
//   owner_e    - which requester owns the in-flight transaction
//   BYTES_*    - legal byte counts for loads and stores
//   norm_bytes - maps any byte count other than 1 or 2 onto 4
package mem_req_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LD   = 2'd2,
    OWN_ST   = 2'd3
  } owner_e;

  localparam logic [2:0] BYTES_1 = 3'd1;
  localparam logic [2:0] BYTES_2 = 3'd2;
  localparam logic [2:0] BYTES_4 = 3'd4;

  function automatic logic [2:0] norm_bytes(input logic [2:0] bytes);
    if (bytes == BYTES_1 || bytes == BYTES_2) begin
      return bytes;
    end
    return BYTES_4;
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// mem_load_ext: combinational load-data extender.
//   i_raw    - raw controller read data, low bytes valid
//   i_bytes  - byte count (1, 2; anything else passes the word through)
//   i_signed - 1 = sign-extend, 0 = zero-extend
//   o_data   - extended word
module mem_load_ext #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] i_raw,
  input  logic [2:0]        i_bytes,
  input  logic              i_signed,
  output logic [DATA_W-1:0] o_data
);
  import mem_req_arbiter_pkg::*;

  always_comb begin
    o_data = i_raw;
    case (i_bytes)
      BYTES_1: o_data = {{(DATA_W - 8){i_signed & i_raw[7]}}, i_raw[7:0]};
      BYTES_2: o_data = {{(DATA_W - 16){i_signed & i_raw[15]}}, i_raw[15:0]};
      default: o_data = i_raw;
    endcase
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: single-owner arbiter in front of the byte-serial memory controller.
// Grants one of fetch/load/store (store > load > fetch), issues one command, waits for
// mc_done and returns the result to the owner with a one-cycle ack. Fetch/load results
// are squashed when a flush hits the transaction in flight.
//   clk, rst (sync, active-high), i_rdy (global enable), i_flush
//   i_if_*  / o_if_*  - instruction fetch port
//   i_ld_*  / o_ld_*  - load port (sign/zero extension done here)
//   i_st_*  / o_st_ack - store port
//   o_mc_*  / i_mc_*  - controller command and completion
// Build option: define ARB_STARVE_GUARD_EN to force a fetch grant after STARVE_LIMIT
// consecutive load/store grants while a fetch waits.
module mem_req_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rdy,
  input  logic              i_flush,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_ack,
  output logic [DATA_W-1:0] o_if_data,
  input  logic              i_ld_req,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [2:0]        i_ld_bytes,
  input  logic              i_ld_signed,
  output logic              o_ld_ack,
  output logic [DATA_W-1:0] o_ld_data,
  input  logic              i_st_req,
  input  logic [ADDR_W-1:0] i_st_addr,
  input  logic [DATA_W-1:0] i_st_data,
  input  logic [2:0]        i_st_bytes,
  output logic              o_st_ack,
  output logic              o_mc_valid,
  output logic              o_mc_wr,
  output logic [ADDR_W-1:0] o_mc_addr,
  output logic [DATA_W-1:0] o_mc_data,
  output logic [2:0]        o_mc_bytes,
  input  logic              i_mc_done,
  input  logic [DATA_W-1:0] i_mc_rdata
);
  import mem_req_arbiter_pkg::*;

  state_e            r_state;
  owner_e            r_owner;
  logic              r_kill;
  logic              r_signed;
  logic [2:0]        r_bytes;
  logic              r_mc_valid;
  logic              r_mc_wr;
  logic [ADDR_W-1:0] r_mc_addr;
  logic [DATA_W-1:0] r_mc_data;
  logic              r_if_ack;
  logic              r_ld_ack;
  logic              r_st_ack;
  logic [DATA_W-1:0] r_if_data;
  logic [DATA_W-1:0] r_ld_data;

  logic              w_force_if;
  logic              w_grant_if;
  logic              w_grant_ld;
  logic              w_grant_st;
  logic              w_kill_now;
  logic [DATA_W-1:0] w_ext_data;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

  logic [CntW-1:0] r_starve_cnt;

  assign w_force_if = (r_starve_cnt == StarveMax) && i_if_req && !i_flush;

  // Counts load/store grants that bypassed a waiting fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (i_rdy) begin
      if (!i_if_req || w_grant_if) begin
        r_starve_cnt <= '0;
      end else if ((w_grant_st || w_grant_ld) && (r_starve_cnt != StarveMax)) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end
    end
  end
`else
  logic w_unused_starve_limit;
  assign w_unused_starve_limit = ^STARVE_LIMIT;
  assign w_force_if = 1'b0;
`endif

  always_comb begin
    w_grant_if = 1'b0;
    w_grant_ld = 1'b0;
    w_grant_st = 1'b0;
    if (r_state == StIdle) begin
      if (w_force_if) begin
        w_grant_if = 1'b1;
      end else if (i_st_req) begin
        w_grant_st = 1'b1;
      end else if (i_ld_req && !i_flush) begin
        w_grant_ld = 1'b1;
      end else if (i_if_req && !i_flush) begin
        w_grant_if = 1'b1;
      end
    end
  end

  // Stores are architecturally committed, so a flush never squashes them.
  assign w_kill_now = i_flush && (r_owner != OWN_ST);

  mem_load_ext #(
    .DATA_W (DATA_W)
  ) u_load_ext (
    .i_raw    (i_mc_rdata),
    .i_bytes  (r_bytes),
    .i_signed (r_signed),
    .o_data   (w_ext_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_owner    <= OWN_NONE;
      r_kill     <= 1'b0;
      r_signed   <= 1'b0;
      r_bytes    <= '0;
      r_mc_valid <= 1'b0;
      r_mc_wr    <= 1'b0;
      r_mc_addr  <= '0;
      r_mc_data  <= '0;
      r_if_ack   <= 1'b0;
      r_ld_ack   <= 1'b0;
      r_st_ack   <= 1'b0;
      r_if_data  <= '0;
      r_ld_data  <= '0;
    end else if (i_rdy) begin
      r_mc_valid <= 1'b0;
      r_if_ack   <= 1'b0;
      r_ld_ack   <= 1'b0;
      r_st_ack   <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_grant_st) begin
            r_owner    <= OWN_ST;
            r_mc_wr    <= 1'b1;
            r_mc_addr  <= i_st_addr;
            r_mc_data  <= i_st_data;
            r_bytes    <= norm_bytes(i_st_bytes);
            r_signed   <= 1'b0;
            r_mc_valid <= 1'b1;
            r_state    <= StIssue;
          end else if (w_grant_ld) begin
            r_owner    <= OWN_LD;
            r_mc_wr    <= 1'b0;
            r_mc_addr  <= i_ld_addr;
            r_mc_data  <= '0;
            r_bytes    <= norm_bytes(i_ld_bytes);
            r_signed   <= i_ld_signed;
            r_mc_valid <= 1'b1;
            r_state    <= StIssue;
          end else if (w_grant_if) begin
            r_owner    <= OWN_IF;
            r_mc_wr    <= 1'b0;
            r_mc_addr  <= i_if_addr;
            r_mc_data  <= '0;
            r_bytes    <= BYTES_4;
            r_signed   <= 1'b0;
            r_mc_valid <= 1'b1;
            r_state    <= StIssue;
          end
        end
        StIssue: begin
          if (w_kill_now) r_kill <= 1'b1;
          r_state <= StWait;
        end
        StWait: begin
          if (w_kill_now) r_kill <= 1'b1;
          if (i_mc_done) begin
            r_state <= StResp;
            // A flush on the completion cycle itself also squashes the result.
            if (!(r_kill || w_kill_now)) begin
              case (r_owner)
                OWN_IF: begin
                  r_if_ack  <= 1'b1;
                  r_if_data <= i_mc_rdata;
                end
                OWN_LD: begin
                  r_ld_ack  <= 1'b1;
                  r_ld_data <= w_ext_data;
                end
                OWN_ST:  r_st_ack <= 1'b1;
                default: ;
              endcase
            end
          end
        end
        StResp: begin
          r_kill  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_if_ack   = r_if_ack;
  assign o_if_data  = r_if_data;
  assign o_ld_ack   = r_ld_ack;
  assign o_ld_data  = r_ld_data;
  assign o_st_ack   = r_st_ack;
  assign o_mc_valid = r_mc_valid;
  assign o_mc_wr    = r_mc_wr;
  assign o_mc_addr  = r_mc_addr;
  assign o_mc_data  = r_mc_data;
  assign o_mc_bytes = r_bytes;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed vectors plus hand-written multi-cycle sequences.
module tb_mem_req_arbiter;

  localparam logic [1:0] K_IF = 2'd0;
  localparam logic [1:0] K_LD = 2'd1;
  localparam logic [1:0] K_ST = 2'd2;

  logic        clk = 1'b0;
  logic        rst, rdy, flush;
  logic        if_req, ld_req, st_req, ld_signed, mc_done;
  logic [31:0] if_addr, ld_addr, st_addr, st_data, mc_rdata;
  logic [2:0]  ld_bytes, st_bytes;
  logic        if_ack, ld_ack, st_ack, mc_valid, mc_wr;
  logic [31:0] if_data, ld_data, mc_addr, mc_data;
  logic [2:0]  mc_bytes;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_req_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .STARVE_LIMIT (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_rdy       (rdy),
    .i_flush     (flush),
    .i_if_req    (if_req),
    .i_if_addr   (if_addr),
    .o_if_ack    (if_ack),
    .o_if_data   (if_data),
    .i_ld_req    (ld_req),
    .i_ld_addr   (ld_addr),
    .i_ld_bytes  (ld_bytes),
    .i_ld_signed (ld_signed),
    .o_ld_ack    (ld_ack),
    .o_ld_data   (ld_data),
    .i_st_req    (st_req),
    .i_st_addr   (st_addr),
    .i_st_data   (st_data),
    .i_st_bytes  (st_bytes),
    .o_st_ack    (st_ack),
    .o_mc_valid  (mc_valid),
    .o_mc_wr     (mc_wr),
    .o_mc_addr   (mc_addr),
    .o_mc_data   (mc_data),
    .o_mc_bytes  (mc_bytes),
    .i_mc_done   (mc_done),
    .i_mc_rdata  (mc_rdata)
  );

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] addr;
    logic [2:0]  bytes;
    logic        sgn;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [2:0]  exp_bytes;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of cycles until mc_valid is seen, or -1 on timeout.
  task automatic wait_valid(output int waited);
    waited = -1;
    for (int i = 1; i <= 20; i++) begin
      clk1();
      if (mc_valid) begin
        waited = i;
        break;
      end
    end
    check("mc_valid_seen", (waited > 0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // Called in the ISSUE cycle; leaves the caller in the RESP cycle.
  task automatic respond(input logic [31:0] rdata);
    clk1();
    check("mc_valid_one_cycle", {31'b0, mc_valid}, 32'd0);
    mc_done  = 1'b1;
    mc_rdata = rdata;
    clk1();
    mc_done  = 1'b0;
    mc_rdata = 32'h0;
  endtask

  task automatic check_acks(input string name, input logic [1:0] kind);
    check({name, "_if_ack"}, {31'b0, if_ack}, {31'b0, kind == K_IF});
    check({name, "_ld_ack"}, {31'b0, ld_ack}, {31'b0, kind == K_LD});
    check({name, "_st_ack"}, {31'b0, st_ack}, {31'b0, kind == K_ST});
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_mc_valid"}, {31'b0, mc_valid}, 32'd0);
    check({name, "_mc_wr"}, {31'b0, mc_wr}, 32'd0);
    check({name, "_mc_addr"}, mc_addr, 32'd0);
    check({name, "_mc_data"}, mc_data, 32'd0);
    check({name, "_mc_bytes"}, {29'b0, mc_bytes}, 32'd0);
    check({name, "_acks"}, {29'b0, if_ack, ld_ack, st_ack}, 32'd0);
    check({name, "_if_data"}, if_data, 32'd0);
    check({name, "_ld_data"}, ld_data, 32'd0);
  endtask

  int          waited;
  logic [31:0] exp_addr[3];
  logic [1:0]  exp_kind[3];
  logic [1:0]  kind_seen;

  initial begin
    vecs[0] = '{K_LD, 32'h100, 3'd1, 1'b1, 32'h0, 32'h0000_0080, 3'd1, 32'hFFFF_FF80};
    vecs[1] = '{K_LD, 32'h100, 3'd1, 1'b0, 32'h0, 32'h0000_0080, 3'd1, 32'h0000_0080};
    vecs[2] = '{K_LD, 32'h204, 3'd2, 1'b1, 32'h0, 32'h1234_8001, 3'd2, 32'hFFFF_8001};
    vecs[3] = '{K_LD, 32'h208, 3'd2, 1'b0, 32'h0, 32'hABCD_8001, 3'd2, 32'h0000_8001};
    vecs[4] = '{K_LD, 32'h20C, 3'd4, 1'b1, 32'h0, 32'h89AB_CDEF, 3'd4, 32'h89AB_CDEF};
    vecs[5] = '{K_LD, 32'h210, 3'd3, 1'b1, 32'h0, 32'h8000_0001, 3'd4, 32'h8000_0001};
    vecs[6] = '{K_LD, 32'h214, 3'd1, 1'b1, 32'h0, 32'hFFFF_FF7F, 3'd1, 32'h0000_007F};
    vecs[7] = '{K_IF, 32'h400, 3'd4, 1'b0, 32'h0, 32'hDEAD_BEEF, 3'd4, 32'hDEAD_BEEF};
    vecs[8] = '{K_ST, 32'h500, 3'd2, 1'b0, 32'h1122_3344, 32'h0, 3'd2, 32'h0};

    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0; ld_signed = 1'b0; mc_done = 1'b0;
    if_addr = '0; ld_addr = '0; st_addr = '0; st_data = '0; mc_rdata = '0;
    ld_bytes = 3'd4; st_bytes = 3'd4;
    repeat (3) clk1();
    rst = 1'b0;
    check_idle_outputs("reset");

    // Table-driven single transactions.
    foreach (vecs[i]) begin
      if_req = (vecs[i].kind == K_IF); if_addr = vecs[i].addr;
      ld_req = (vecs[i].kind == K_LD); ld_addr = vecs[i].addr;
      ld_bytes = vecs[i].bytes; ld_signed = vecs[i].sgn;
      st_req = (vecs[i].kind == K_ST); st_addr = vecs[i].addr;
      st_data = vecs[i].wdata; st_bytes = vecs[i].bytes;
      wait_valid(waited);
      check("vec_mc_wr", {31'b0, mc_wr}, {31'b0, vecs[i].kind == K_ST});
      check("vec_mc_addr", mc_addr, vecs[i].addr);
      check("vec_mc_bytes", {29'b0, mc_bytes}, {29'b0, vecs[i].exp_bytes});
      check("vec_mc_data", mc_data, vecs[i].wdata);
      respond(vecs[i].rdata);
      check_acks("vec", vecs[i].kind);
      if (vecs[i].kind == K_LD) check("vec_ld_data", ld_data, vecs[i].exp_data);
      if (vecs[i].kind == K_IF) check("vec_if_data", if_data, vecs[i].exp_data);
      if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
      clk1();
      check("vec_ack_pulse", {29'b0, if_ack, ld_ack, st_ack}, 32'd0);
    end

    // Priority: all three at once -> store, load, fetch with one idle cycle between.
    st_addr = 32'h10; st_data = 32'h5555_AAAA; st_bytes = 3'd4;
    ld_addr = 32'h20; ld_bytes = 3'd4; ld_signed = 1'b0;
    if_addr = 32'h30;
    st_req = 1'b1; ld_req = 1'b1; if_req = 1'b1;
    exp_addr[0] = 32'h10; exp_addr[1] = 32'h20; exp_addr[2] = 32'h30;
    exp_kind[0] = K_ST; exp_kind[1] = K_LD; exp_kind[2] = K_IF;
    for (int k = 0; k < 3; k++) begin
      wait_valid(waited);
      if (k > 0) check("prio_gap", waited, 2);
      check("prio_addr", mc_addr, exp_addr[k]);
      respond(32'h0000_1000 + k);
      check_acks("prio", exp_kind[k]);
      if (exp_kind[k] == K_ST) st_req = 1'b0;
      if (exp_kind[k] == K_LD) ld_req = 1'b0;
      if (exp_kind[k] == K_IF) if_req = 1'b0;
    end
    check("prio_if_data", if_data, 32'h0000_1002);
    clk1();

    // Flush during WAIT kills the load; the waiting fetch is granted next.
    ld_addr = 32'h600; ld_bytes = 3'd4; if_addr = 32'h700;
    ld_req = 1'b1; if_req = 1'b1;
    wait_valid(waited);
    check("kill_ld_addr", mc_addr, 32'h600);
    clk1();
    flush = 1'b1;
    clk1();
    flush = 1'b0;
    mc_done = 1'b1; mc_rdata = 32'h1234_5678;
    clk1();
    mc_done = 1'b0; mc_rdata = 32'h0;
    check_acks("kill_wait", 2'd3);
    ld_req = 1'b0;
    wait_valid(waited);
    check("kill_next_fetch", mc_addr, 32'h700);
    respond(32'hCAFE_F00D);
    check_acks("kill_fetch", K_IF);
    check("kill_fetch_data", if_data, 32'hCAFE_F00D);
    if_req = 1'b0;
    clk1();

    // Flush on the same cycle as mc_done also kills.
    ld_addr = 32'h800; ld_req = 1'b1;
    wait_valid(waited);
    clk1();
    flush = 1'b1; mc_done = 1'b1; mc_rdata = 32'h0000_00FF;
    clk1();
    flush = 1'b0; mc_done = 1'b0; mc_rdata = 32'h0;
    check_acks("kill_done", 2'd3);
    ld_req = 1'b0;
    clk1();

    // Store granted while flush is high and is never squashed.
    st_addr = 32'h880; st_data = 32'hA5A5_5A5A; st_bytes = 3'd4;
    st_req = 1'b1; flush = 1'b1;
    wait_valid(waited);
    check("st_flush_wr", {31'b0, mc_wr}, 32'd1);
    check("st_flush_bytes", {29'b0, mc_bytes}, 32'd4);
    check("st_flush_data", mc_data, 32'hA5A5_5A5A);
    respond(32'h0);
    check_acks("st_flush", K_ST);
    st_req = 1'b0; flush = 1'b0;
    clk1();

    // Continuous stores with a pending fetch.
    if_addr = 32'h900; if_req = 1'b1;
    st_addr = 32'hA00; st_req = 1'b1;
    for (int g = 0; g < 5; g++) begin
      wait_valid(waited);
      kind_seen = mc_wr ? K_ST : K_IF;
`ifdef ARB_STARVE_GUARD_EN
      check("starve_owner", {30'b0, kind_seen}, (g == 4) ? {30'b0, K_IF} : {30'b0, K_ST});
`else
      check("starve_owner", {30'b0, kind_seen}, {30'b0, K_ST});
`endif
      respond(32'h0000_0900);
      check_acks("starve", kind_seen);
    end
    if_req = 1'b0; st_req = 1'b0;
    clk1();

    // Reset in WAIT: back to IDLE, late completion ignored.
    ld_addr = 32'hB00; ld_bytes = 3'd4; ld_req = 1'b1;
    wait_valid(waited);
    clk1();
    rst = 1'b1;
    clk1();
    rst = 1'b0; ld_req = 1'b0;
    check_idle_outputs("rst_wait");
    mc_done = 1'b1; mc_rdata = 32'h7777_7777;
    clk1();
    mc_done = 1'b0; mc_rdata = 32'h0;
    check_acks("rst_late_done", 2'd3);
    clk1();
    check_acks("rst_late_done2", 2'd3);
    check("rst_no_issue", {31'b0, mc_valid}, 32'd0);

    // rdy=0 for 3 cycles in WAIT, with a completion offered while frozen.
    ld_addr = 32'hC00; ld_bytes = 3'd2; ld_signed = 1'b1; ld_req = 1'b1;
    wait_valid(waited);
    clk1();
    rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      mc_done  = (c == 1);
      mc_rdata = (c == 1) ? 32'h0000_1111 : 32'h0;
      clk1();
      check("rdy_hold_addr", mc_addr, 32'hC00);
      check("rdy_hold_valid", {31'b0, mc_valid}, 32'd0);
      check("rdy_hold_ack", {31'b0, ld_ack}, 32'd0);
    end
    mc_done = 1'b0; mc_rdata = 32'h0;
    rdy = 1'b1;
    clk1();
    check("rdy_done_ignored", {31'b0, ld_ack}, 32'd0);
    mc_done = 1'b1; mc_rdata = 32'h0000_F00F;
    clk1();
    mc_done = 1'b0; mc_rdata = 32'h0;
    check_acks("rdy_resume", K_LD);
    check("rdy_resume_data", ld_data, 32'hFFFF_F00F);
    ld_req = 1'b0;
    clk1();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
